// File: rtl/alu_arbiter.sv
// Purpose: shares one ALU between two requesters, round-robin with an optional ownership lock.
// Latency: request handshake at edge t, EXEC t+1, CAPT t+2, response valid from t+3.
// Backpressure: response holds until RspReady; no request is accepted outside IDLE.
module alu_arbiter (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid0,
    input  logic        ReqValid1,
    output logic        ReqReady0,
    output logic        ReqReady1,
    input  logic [15:0] ReqA0,
    input  logic [15:0] ReqA1,
    input  logic [15:0] ReqB0,
    input  logic [15:0] ReqB1,
    input  logic [4:0]  ReqFunSel0,
    input  logic [4:0]  ReqFunSel1,
    input  logic        ReqWF0,
    input  logic        ReqWF1,
    input  logic        ReqLock0,
    input  logic        ReqLock1,
    output logic        RspValid,
    input  logic        RspReady,
    output logic        RspId,
    output logic [15:0] RspResult,
    output logic [3:0]  RspFlags,
    output logic [15:0] AluA,
    output logic [15:0] AluB,
    output logic [4:0]  AluFunSel,
    output logic        AluWF,
    input  logic [15:0] AluOut,
    input  logic [3:0]  AluFlags
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [4:0]  fun_q, fun_d;
    logic        wf_q, wf_d;
    logic        lock_q, lock_d;     // ownership held by id_q while set
    logic        id_q, id_d;         // current owner / response tag
    logic        last_q, last_d;     // requester granted most recently
    logic [15:0] result_q, result_d;
    logic [3:0]  flags_q, flags_d;

    logic        grant0, grant1;

    // Pick the eligible winner in IDLE: lock owner only, else round-robin on a tie.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            if (lock_q) begin
                grant0 = ~id_q & ReqValid0;
                grant1 =  id_q & ReqValid1;
            end else if (ReqValid0 && ReqValid1) begin
                grant0 =  last_q;
                grant1 = ~last_q;
            end else begin
                grant0 = ReqValid0;
                grant1 = ReqValid1;
            end
        end
    end

    // Next-state and datapath capture for the IDLE/EXEC/CAPT/RESP sequence.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        fun_d    = fun_q;
        wf_d     = wf_q;
        lock_d   = lock_q;
        id_d     = id_q;
        last_d   = last_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    a_d     = grant1 ? ReqA1      : ReqA0;
                    b_d     = grant1 ? ReqB1      : ReqB0;
                    fun_d   = grant1 ? ReqFunSel1 : ReqFunSel0;
                    wf_d    = grant1 ? ReqWF1     : ReqWF0;
                    lock_d  = grant1 ? ReqLock1   : ReqLock0;
                    id_d    = grant1;
                    last_d  = grant1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // ALU result is combinational; flags register on this same edge.
                result_d = AluOut;
                state_d  = CAPT;
            end
            CAPT: begin
                flags_d = AluFlags;
                state_d = RESP;
            end
            RESP: begin
                if (RspReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched-operand registers with asynchronous clear.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            fun_q    <= '0;
            wf_q     <= 1'b0;
            lock_q   <= 1'b0;
            id_q     <= 1'b0;
            last_q   <= 1'b1;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            fun_q    <= fun_d;
            wf_q     <= wf_d;
            lock_q   <= lock_d;
            id_q     <= id_d;
            last_q   <= last_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    // Outputs decode directly from registers so reset clears them, AluWF included, at once.
    always_comb begin
        ReqReady0 = grant0;
        ReqReady1 = grant1;
        RspValid  = (state_q == RESP);
        RspId     = id_q;
        RspResult = result_q;
        RspFlags  = flags_q;
        AluA      = a_q;
        AluB      = b_q;
        AluFunSel = fun_q;
        AluWF     = (state_q == EXEC) && wf_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose: directed self-checking bench for alu_arbiter with a small behavioural ALU.
// Latency: checks EXEC/CAPT/RESP timing relative to the request handshake.
// Backpressure: exercises RspReady stalls and lock-based refusal of the other requester.
module tb_alu_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ReqValid0, ReqValid1;
    logic        ReqReady0, ReqReady1;
    logic [15:0] ReqA0, ReqA1, ReqB0, ReqB1;
    logic [4:0]  ReqFunSel0, ReqFunSel1;
    logic        ReqWF0, ReqWF1, ReqLock0, ReqLock1;
    logic        RspValid, RspReady, RspId;
    logic [15:0] RspResult;
    logic [3:0]  RspFlags;
    logic [15:0] AluA, AluB, AluOut;
    logic [4:0]  AluFunSel;
    logic        AluWF;
    logic [3:0]  AluFlags;

    int checks = 0;
    int failures = 0;

    alu_arbiter dut (
        .Clock(Clock), .Reset(Reset),
        .ReqValid0(ReqValid0), .ReqValid1(ReqValid1),
        .ReqReady0(ReqReady0), .ReqReady1(ReqReady1),
        .ReqA0(ReqA0), .ReqA1(ReqA1), .ReqB0(ReqB0), .ReqB1(ReqB1),
        .ReqFunSel0(ReqFunSel0), .ReqFunSel1(ReqFunSel1),
        .ReqWF0(ReqWF0), .ReqWF1(ReqWF1),
        .ReqLock0(ReqLock0), .ReqLock1(ReqLock1),
        .RspValid(RspValid), .RspReady(RspReady), .RspId(RspId),
        .RspResult(RspResult), .RspFlags(RspFlags),
        .AluA(AluA), .AluB(AluB), .AluFunSel(AluFunSel), .AluWF(AluWF),
        .AluOut(AluOut), .AluFlags(AluFlags)
    );

    always #5 Clock = ~Clock;

    // Behavioural ALU: pass-A, ADD, ADC; flags {Z,C,N,O} registered when WF is set.
    logic [3:0]  alu_flags_q = 4'h0;
    logic [3:0]  alu_nflags;
    logic [16:0] alu_sum;
    always_comb begin
        alu_sum    = '0;
        AluOut     = '0;
        alu_nflags = alu_flags_q;
        case (AluFunSel)
            5'b10000: begin
                AluOut     = AluA;
                alu_nflags = {AluA == 16'h0, alu_flags_q[2], AluA[15], alu_flags_q[0]};
            end
            5'b10100, 5'b10101: begin
                alu_sum    = {1'b0, AluA} + {1'b0, AluB} + {16'h0, AluFunSel[0] & alu_flags_q[2]};
                AluOut     = alu_sum[15:0];
                alu_nflags = {alu_sum[15:0] == 16'h0, alu_sum[16], alu_sum[15],
                              (AluA[15] == AluB[15]) && (alu_sum[15] != AluA[15])};
            end
            default: ;
        endcase
    end
    always @(posedge Clock) if (AluWF) alu_flags_q <= alu_nflags;
    assign AluFlags = alu_flags_q;

    task automatic drive_req(input logic id, input logic [15:0] a, input logic [15:0] b,
                             input logic [4:0] fs, input logic wf, input logic lk);
        if (id == 1'b0) begin
            ReqA0 = a; ReqB0 = b; ReqFunSel0 = fs; ReqWF0 = wf; ReqLock0 = lk; ReqValid0 = 1'b1;
        end else begin
            ReqA1 = a; ReqB1 = b; ReqFunSel1 = fs; ReqWF1 = wf; ReqLock1 = lk; ReqValid1 = 1'b1;
        end
    endtask

    // Issues one request, waits (bounded) for grant and response, consumes it.
    task automatic run_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                          input logic [4:0] fs, input logic wf, input logic lk,
                          output logic rid, output logic [15:0] res, output logic [3:0] flg,
                          output int acc_lat, output int rsp_lat);
        drive_req(id, a, b, fs, wf, lk);
        acc_lat = -1;
        rsp_lat = -1;
        rid = 1'b0; res = '0; flg = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if ((id == 1'b0 && ReqReady0) || (id == 1'b1 && ReqReady1)) begin
                acc_lat = i;
                break;
            end
        end
        @(posedge Clock); #1;
        ReqValid0 = 1'b0; ReqValid1 = 1'b0;
        if (acc_lat >= 0) begin
            for (int i = 1; i <= 20; i++) begin
                @(negedge Clock);
                if (RspValid) begin
                    rsp_lat = i; rid = RspId; res = RspResult; flg = RspFlags;
                    break;
                end
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_reset;
        ReqValid0 = 0; ReqValid1 = 0; RspReady = 1;
        drive_req(0, 16'h0, 16'h0, 5'h0, 0, 0); ReqValid0 = 0;
        drive_req(1, 16'h0, 16'h0, 5'h0, 0, 0); ReqValid1 = 0;
        Reset = 1'b0;
        #3;
        checks++;
        if ({ReqReady0, ReqReady1, RspValid, RspId, AluWF} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl: got %b expected 00000", {ReqReady0, ReqReady1, RspValid, RspId, AluWF});
        end
        checks++;
        if ({RspResult, RspFlags, AluA, AluB, AluFunSel} !== 57'h0) begin
            failures++; $display("FAIL reset_data: got %h expected 0", {RspResult, RspFlags, AluA, AluB, AluFunSel});
        end
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b1;
    endtask

    task automatic test_basic;
        int wf_cycles = 0;
        int rsp_cyc = -1;
        logic rid = 1'b0;
        logic [15:0] res = '0;
        logic [3:0] flg = '0;
        RspReady = 1;
        drive_req(0, 16'h0005, 16'h0003, 5'b10100, 1, 0);
        @(negedge Clock);
        checks++;
        if ({ReqReady0, ReqReady1} !== 2'b10) begin
            failures++; $display("FAIL basic_ready: got %b expected 10", {ReqReady0, ReqReady1});
        end
        @(posedge Clock); #1 ReqValid0 = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge Clock);
            if (AluWF) wf_cycles++;
            if (c == 1) begin
                checks++;
                if ({AluA, AluB, AluFunSel, AluWF} !== {16'h0005, 16'h0003, 5'b10100, 1'b1}) begin
                    failures++; $display("FAIL basic_exec_drive: got %h expected %h",
                        {AluA, AluB, AluFunSel, AluWF}, {16'h0005, 16'h0003, 5'b10100, 1'b1});
                end
            end
            if (RspValid && rsp_cyc < 0) begin
                rsp_cyc = c; rid = RspId; res = RspResult; flg = RspFlags;
            end
        end
        @(posedge Clock); #1;
        checks++;
        if (wf_cycles !== 1) begin failures++; $display("FAIL basic_wf_cycles: got %0d expected 1", wf_cycles); end
        checks++;
        if (rsp_cyc !== 3) begin failures++; $display("FAIL basic_latency: got %0d expected 3", rsp_cyc); end
        checks++;
        if ({rid, res, flg} !== {1'b0, 16'h0008, 4'b0000}) begin
            failures++; $display("FAIL basic_rsp: got id=%0d res=%h flg=%b expected id=0 res=0008 flg=0000", rid, res, flg);
        end
    endtask

    task automatic test_alternate;
        int gid[$];
        int gcyc[$];
        int rid[$];
        int both = 0;
        Reset = 0; @(posedge Clock); #1 Reset = 1;
        RspReady = 1;
        drive_req(0, 16'h0001, 16'h0001, 5'b10100, 1, 0);
        drive_req(1, 16'h0001, 16'h0001, 5'b10100, 1, 0);
        for (int c = 0; c < 16; c++) begin
            @(negedge Clock);
            if (ReqReady0 && ReqReady1) both++;
            if (ReqReady0 || ReqReady1) begin gid.push_back(int'(ReqReady1)); gcyc.push_back(c); end
            if (RspValid) rid.push_back(int'(RspId));
        end
        @(posedge Clock); #1 ReqValid0 = 0; ReqValid1 = 0;
        checks++;
        if (both !== 0) begin failures++; $display("FAIL alt_both_ready: got %0d expected 0", both); end
        checks++;
        if (gid.size() !== 4 || rid.size() !== 4) begin
            failures++; $display("FAIL alt_count: got grants=%0d rsps=%0d expected 4 4", gid.size(), rid.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (gid[i] !== i % 2 || gcyc[i] !== 4 * i || rid[i] !== i % 2) begin
                    failures++; $display("FAIL alt_grant%0d: got id=%0d cyc=%0d rsp=%0d expected id=%0d cyc=%0d rsp=%0d",
                        i, gid[i], gcyc[i], rid[i], i % 2, 4 * i, i % 2);
                end
            end
        end
    endtask

    task automatic test_lock32;
        int early = 0;
        RspReady = 1;
        drive_req(1, 16'hFFFF, 16'h0001, 5'b10100, 1, 1);
        @(negedge Clock);
        checks++;
        if (ReqReady1 !== 1'b1) begin failures++; $display("FAIL lock_add_ready: got %b expected 1", ReqReady1); end
        @(posedge Clock); #1;
        drive_req(1, 16'h0000, 16'h0000, 5'b10101, 1, 0);
        drive_req(0, 16'h0007, 16'h0001, 5'b10100, 0, 0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clock);
            if (c < 8 && ReqReady0) early++;
            if (c == 3) begin
                checks++;
                if ({RspValid, RspId, RspResult, RspFlags} !== {1'b1, 1'b1, 16'h0000, 4'b1100}) begin
                    failures++; $display("FAIL lock_add_rsp: got v=%b id=%b res=%h flg=%b expected 1 1 0000 1100",
                        RspValid, RspId, RspResult, RspFlags);
                end
            end
            if (c == 4) begin
                checks++;
                if ({ReqReady0, ReqReady1} !== 2'b01) begin
                    failures++; $display("FAIL lock_adc_ready: got %b expected 01", {ReqReady0, ReqReady1});
                end
                @(posedge Clock); #1 ReqValid1 = 0;
            end
            if (c == 7) begin
                checks++;
                if ({RspValid, RspId, RspResult, RspFlags} !== {1'b1, 1'b1, 16'h0001, 4'b0000}) begin
                    failures++; $display("FAIL lock_adc_rsp: got v=%b id=%b res=%h flg=%b expected 1 1 0001 0000",
                        RspValid, RspId, RspResult, RspFlags);
                end
            end
            if (c == 8) begin
                checks++;
                if (ReqReady0 !== 1'b1) begin failures++; $display("FAIL lock_release: got %b expected 1", ReqReady0); end
            end
        end
        checks++;
        if (early !== 0) begin failures++; $display("FAIL lock_refuse0: got %0d early grants expected 0", early); end
        @(posedge Clock); #1 ReqValid0 = 0;
        repeat (3) @(negedge Clock);
        checks++;
        if ({RspValid, RspId, RspResult} !== {1'b1, 1'b0, 16'h0008}) begin
            failures++; $display("FAIL lock_req0_rsp: got v=%b id=%b res=%h expected 1 0 0008", RspValid, RspId, RspResult);
        end
        @(posedge Clock); #1;
    endtask

    task automatic test_backpressure;
        int bad = 0;
        RspReady = 0;
        drive_req(0, 16'h0002, 16'h0003, 5'b10100, 1, 0);
        @(negedge Clock);
        checks++;
        if (ReqReady0 !== 1'b1) begin failures++; $display("FAIL bp_ready0: got %b expected 1", ReqReady0); end
        @(posedge Clock); #1 ReqValid0 = 0;
        drive_req(1, 16'h0010, 16'h0020, 5'b10100, 1, 0);
        repeat (2) @(negedge Clock);
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            if ({RspValid, RspId, RspResult, RspFlags, ReqReady1} !== {1'b1, 1'b0, 16'h0005, 4'b0000, 1'b0}) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL bp_stall_stable: got %0d bad cycles expected 0", bad); end
        @(posedge Clock); #1 RspReady = 1;
        @(negedge Clock);
        checks++;
        if ({RspValid, ReqReady1} !== 2'b10) begin
            failures++; $display("FAIL bp_release: got %b expected 10", {RspValid, ReqReady1});
        end
        @(negedge Clock);
        checks++;
        if ({RspValid, ReqReady1} !== 2'b01) begin
            failures++; $display("FAIL bp_next_accept: got %b expected 01", {RspValid, ReqReady1});
        end
        @(posedge Clock); #1 ReqValid1 = 0;
        repeat (3) @(negedge Clock);
        checks++;
        if ({RspValid, RspId, RspResult} !== {1'b1, 1'b1, 16'h0030}) begin
            failures++; $display("FAIL bp_req1_rsp: got v=%b id=%b res=%h expected 1 1 0030", RspValid, RspId, RspResult);
        end
        @(posedge Clock); #1;
    endtask

    task automatic test_reset_mid_exec;
        logic [3:0] saved;
        int seen = 0;
        logic rid;
        logic [15:0] res;
        logic [3:0] flg;
        int acc, lat;
        saved = alu_flags_q;
        RspReady = 1;
        drive_req(0, 16'hFFFF, 16'h0001, 5'b10100, 1, 0);
        @(negedge Clock);
        @(posedge Clock); #1 ReqValid0 = 0;
        #1;
        checks++;
        if (AluWF !== 1'b1) begin failures++; $display("FAIL rst_exec_wf: got %b expected 1", AluWF); end
        Reset = 0;
        #1;
        checks++;
        if ({AluWF, RspValid, AluA, AluFunSel} !== 23'h0) begin
            failures++; $display("FAIL rst_async_clear: got %h expected 0", {AluWF, RspValid, AluA, AluFunSel});
        end
        @(posedge Clock); #1;
        checks++;
        if (alu_flags_q !== saved) begin
            failures++; $display("FAIL rst_no_flag_write: got %b expected %b", alu_flags_q, saved);
        end
        Reset = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            if (RspValid) seen++;
        end
        @(posedge Clock); #1;
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL rst_no_rsp: got %0d cycles expected 0", seen); end
        run_op(1, 16'h0004, 16'h0004, 5'b10100, 1, 0, rid, res, flg, acc, lat);
        checks++;
        if (acc !== 0 || lat !== 3 || {rid, res} !== {1'b1, 16'h0008}) begin
            failures++; $display("FAIL rst_then_accept: got acc=%0d lat=%0d id=%b res=%h expected 0 3 1 0008", acc, lat, rid, res);
        end
    endtask

    task automatic test_passa_noflags;
        logic rid;
        logic [15:0] res;
        logic [3:0] flg;
        int acc, lat;
        run_op(0, 16'hFFFF, 16'h0001, 5'b10100, 1, 0, rid, res, flg, acc, lat);
        checks++;
        if ({res, flg} !== {16'h0000, 4'b1100} || lat !== 3) begin
            failures++; $display("FAIL pass_prior_add: got res=%h flg=%b lat=%0d expected 0000 1100 3", res, flg, lat);
        end
        run_op(0, 16'h1234, 16'h5555, 5'b10000, 0, 0, rid, res, flg, acc, lat);
        checks++;
        if ({rid, res, flg} !== {1'b0, 16'h1234, 4'b1100} || lat !== 3) begin
            failures++; $display("FAIL pass_a_wf0: got id=%b res=%h flg=%b lat=%0d expected 0 1234 1100 3", rid, res, flg, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alternate();
        test_lock32();
        test_backpressure();
        test_reset_mid_exec();
        test_passa_noflags();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single ArithmeticLogicUnit between two requesters (e.g. the instruction-execution path and an address-calculation path), granting it round-robin with an optional lock for multi-operation sequences such as 32-bit add via ADD then ADC. It latches the winner's operands, drives the ALU through a fixed execute/capture sequence, and returns the result and the post-operation flags on a shared response channel tagged with the requester ID.

## Interface

No parameters; widths are fixed by the ALU (16-bit data, 5-bit FunSel, 4-bit flags).

- Clock  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- ReqValid0, ReqValid1  in  1  request present from requester 0/1.
- ReqReady0, ReqReady1  out  1  request accepted on an edge where Valid and Ready are both 1.
- ReqA0, ReqA1, ReqB0, ReqB1  in  16  operands.
- ReqFunSel0, ReqFunSel1  in  5  ALU function code.
- ReqWF0, ReqWF1  in  1  update ALU flags with this operation.
- ReqLock0, ReqLock1  in  1  keep ownership after this operation.
- RspValid  out  1  response available.
- RspReady  in  1  response consumed when RspValid and RspReady are both 1.
- RspId  out  1  requester the response belongs to.
- RspResult  out  16  captured ALUOut.
- RspFlags  out  4  captured FlagsOut {Z,C,N,O} = bits {3,2,1,0}.
- AluA, AluB  out  16  drive ALU A and B.
- AluFunSel  out  5  drives ALU FunSel.
- AluWF  out  1  drives ALU WF.
- AluOut  in  16  from ALU ALUOut (combinational).
- AluFlags  in  4  from ALU FlagsOut (registered on Clock).

## Operation

- The FSM has four states: IDLE, EXEC, CAPT and RESP.
- **IDLE**
  - ReqReadyN is 1 only for the eligible winner.
  - Eligibility without lock:
    - If both requesters are valid, the one not granted last wins.
    - If only one is valid, it wins.
  - With lock held by owner N, only N is eligible; the other's ReqReady stays 0 even when the owner is idle.
  - On handshake, latch A, B, FunSel, WF, Lock and Id, update the last-grant pointer, and go to EXEC.
- **EXEC** (1 cycle)
  - AluA/AluB/AluFunSel are driven from the latched values; AluWF is the latched WF.
  - At the closing edge, capture AluOut into RspResult. The ALU flags update on this same edge, so flag-dependent codes (ADC 00101/10101, CSL/CSR) see the pre-operation carry.
  - Go to CAPT.
- **CAPT** (1 cycle)
  - ALU inputs are held and AluWF is 0.
  - At the closing edge, capture AluFlags into RspFlags. AluOut is not recaptured.
  - Go to RESP.
- **RESP**
  - RspValid is 1, with RspId/RspResult/RspFlags stable.
  - AluWF is 0.
  - Wait for RspReady; on handshake go to IDLE.
- **Lock**
  - The lock register is set to the latched Lock at the handshake of every accepted request.
  - Owner N releases the lock by issuing a request with Lock=0.
  - The lock is not released by dropping ReqValid.
- When AluWF=0, RspFlags reports the unchanged ALU flags.

## Timing

- Reset values:
  - State is IDLE.
  - All ReqReady, RspValid, RspId, RspResult, RspFlags, AluA, AluB, AluFunSel and AluWF are 0.
  - The lock is clear.
  - The last-grant pointer is 1, so requester 0 wins the first tie.
- Latency:
  - Request handshake at edge t.
  - EXEC is cycle t+1 (AluWF high for exactly this cycle).
  - CAPT is cycle t+2.
  - RspValid=1 from cycle t+3.
- Throughput: with RspReady tied to 1, one operation every 4 cycles; ReqReady is high only in IDLE.
- A request not accepted must be held stable by the requester; the block samples only at handshake.
- A requester deasserting ReqValid while it is not ready causes no state change.
- Response backpressure: RspValid and the data hold indefinitely, and no new request is accepted during that time.
- Reset mid-operation:
  - All state returns to reset values immediately and any in-flight response is lost.
  - AluWF drops to 0 asynchronously, so no flag write occurs after Reset falls.
- Simultaneous valid from both requesters in the same IDLE cycle: exactly one ReqReady is 1.

## Test plan

- Reset, then ReqValid0 with A=0x0005, B=0x0003, FunSel=10100, WF=1 -> ReqReady0=1 in the first cycle; AluWF=1 for exactly one cycle; RspValid 3 cycles after handshake with RspId=0, RspResult=0x0008, RspFlags=0000.
- Both requesters valid continuously, RspReady=1 -> grants alternate 0,1,0,1; requester 1 never starves; one response every 4 cycles.
- 32-bit add: requester 1 sends ADD A=0xFFFF, B=0x0001, Lock=1 (result 0x0000, flags Z=1 C=1), then ADC A=0x0000, B=0x0000, Lock=0 while requester 0 is also valid -> requester 0 is refused until the ADC completes; ADC RspResult=0x0001; requester 0 granted next.
- RspReady held 0 for 10 cycles with a request pending on requester 1 -> RspValid/data stable; ReqReady1=0 throughout; accepted one cycle after the response handshake.
- Reset asserted during EXEC of a WF=1 operation -> outputs 0 immediately; no response is issued; the block is IDLE and accepts a new request after Reset rises.
- FunSel=10000 (pass A), WF=0, after a prior op left C=1 -> RspFlags equals the prior flags unchanged; RspResult=A.
